// File: rtl/audio_pwm_player_if.sv
// Sample strobe from the SPI audio receiver into the PWM player.
// Single-cycle push, no backpressure: the consumer drops samples it cannot store.
interface audio_pwm_player_if;
    logic        data_ready;
    logic [15:0] audio_in;

    modport master (output data_ready, output audio_in);
    modport slave  (input  data_ready, input  audio_in);
endinterface

// File: rtl/audio_pwm_player.sv
// FIFO-buffered sample player: pops one sample per sample tick into a glitch-free PWM duty.
// Latency: pop -> next PWM period + 1 clk; no backpressure, full-FIFO writes drop and set overflow.
module audio_pwm_player #(
    parameter int CLK_HZ      = 25_000_000,
    parameter int SAMPLE_HZ   = 16_000,
    parameter int PWM_BITS    = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int START_LEVEL = 8
) (
    input  logic                        clk_25mhz,
    input  logic                        reset_n,
    audio_pwm_player_if.slave           snk,
    output logic                        pwm_out,
    output logic                        playing,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    output logic                        underflow
);
    localparam int DIV = CLK_HZ / SAMPLE_HZ;
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam logic [PWM_BITS-1:0] MID = {1'b1, {(PWM_BITS-1){1'b0}}};

    typedef enum logic {FILL, PLAY} state_t;

    state_t              state_q, state_d;
    logic [TW-1:0]       tick_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty_pending, duty_pending_d;
    logic [PWM_BITS-1:0] duty_active;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [15:0]         mem [FIFO_DEPTH];
    logic                sample_tick, full, empty, push, pop, set_unf;

    assign sample_tick = (tick_cnt == TW'(DIV - 1));
    assign full        = (fifo_level == LW'(FIFO_DEPTH));
    assign empty       = (fifo_level == '0);
    assign push        = snk.data_ready && !full;
    assign playing     = (state_q == PLAY);

    // Pop decisions use the pre-cycle level, so a same-cycle push into an empty FIFO is not seen.
    always_comb begin
        state_d        = state_q;
        duty_pending_d = duty_pending;
        pop            = 1'b0;
        set_unf        = 1'b0;
        case (state_q)
            FILL: begin
                duty_pending_d = MID;
                if (sample_tick && (fifo_level >= LW'(START_LEVEL))) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (sample_tick) begin
                    if (!empty) begin
                        pop            = 1'b1;
                        duty_pending_d = PWM_BITS'((mem[rd_ptr] ^ 16'h8000) >> (16 - PWM_BITS));
                    end else begin
                        set_unf        = 1'b1;
                        duty_pending_d = MID;
                        state_d        = FILL;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk_25mhz) begin
        if (push) begin
            mem[wr_ptr] <= snk.audio_in;
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (!reset_n) begin
            state_q      <= FILL;
            tick_cnt     <= '0;
            pwm_cnt      <= '0;
            duty_pending <= MID;
            duty_active  <= MID;
            pwm_out      <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt     <= sample_tick ? '0 : tick_cnt + 1'b1;
            duty_pending <= duty_pending_d;
            pwm_cnt      <= pwm_cnt + 1'b1;
            pwm_out      <= (pwm_cnt < duty_active);
            // Duty only changes at the period boundary so no period is ever truncated.
            if (pwm_cnt == '1) begin
                duty_active <= duty_pending;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
            if (snk.data_ready && full) begin
                overflow <= 1'b1;
            end
            if (set_unf) begin
                underflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_audio_pwm_player.sv
// Directed + random bench for audio_pwm_player against a queue-based reference model.
module tb_audio_pwm_player;
    localparam int DIV   = 32;
    localparam int PER   = 16;
    localparam int DEPTH = 4;
    localparam int START = 2;
    localparam int MIDV  = 8;

    logic       clk_25mhz = 1'b0;
    logic       reset_n   = 1'b0;
    logic       pwm_out, playing, overflow, underflow;
    logic [2:0] fifo_level;

    audio_pwm_player_if bus ();

    audio_pwm_player #(
        .CLK_HZ(3200), .SAMPLE_HZ(100), .PWM_BITS(4), .FIFO_DEPTH(DEPTH), .START_LEVEL(START)
    ) dut (
        .clk_25mhz (clk_25mhz),
        .reset_n   (reset_n),
        .snk       (bus.slave),
        .pwm_out   (pwm_out),
        .playing   (playing),
        .fifo_level(fifo_level),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk_25mhz = ~clk_25mhz;

    int total = 0;
    int bad   = 0;

    // Reference model: sample queue plus cycle count since reset release.
    logic [15:0] q[$];
    bit m_play, m_ovf, m_unf, m_pwm;
    int m_k, m_dp, m_da;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int conv(input logic [15:0] s);
        int v;
        v = int'($signed(s)) + 32768;
        return v / (65536 / PER);
    endfunction

    task automatic model_edge(input logic rn, input logic dr, input logic [15:0] d);
        int pre, pc, old_dp;
        bit tick;
        if (!rn) begin
            q.delete();
            m_play = 0; m_ovf = 0; m_unf = 0; m_pwm = 0;
            m_k = 0; m_dp = MIDV; m_da = MIDV;
            return;
        end
        tick   = ((m_k % DIV) == DIV - 1);
        pc     = m_k % PER;
        pre    = q.size();
        old_dp = m_dp;
        if (tick) begin
            if (!m_play) begin
                if (pre >= START) m_play = 1;
            end else if (pre > 0) begin
                m_dp = conv(q.pop_front());
            end else begin
                m_unf = 1; m_dp = MIDV; m_play = 0;
            end
        end
        if (dr) begin
            if (pre < DEPTH) q.push_back(d);
            else m_ovf = 1;
        end
        m_pwm = (pc < m_da);
        if (pc == PER - 1) m_da = old_dp;
        m_k++;
    endtask

    task automatic step(input logic dr, input logic [15:0] d, input logic rn);
        bus.data_ready = dr;
        bus.audio_in   = d;
        reset_n        = rn;
        @(posedge clk_25mhz);
        model_edge(rn, dr, d);
        #1;
        chk("pwm_out",    32'(pwm_out),    32'(m_pwm));
        chk("playing",    32'(playing),    32'(m_play));
        chk("fifo_level", 32'(fifo_level), 32'(q.size()));
        chk("overflow",   32'(overflow),   32'(m_ovf));
        chk("underflow",  32'(underflow),  32'(m_unf));
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 16'h0, 1'b1);
    endtask

    task automatic count_high(input int n, output int h);
        h = 0;
        repeat (n) begin
            step(1'b0, 16'h0, 1'b1);
            h += int'(pwm_out);
        end
    endtask

    initial begin
        int b, h;
        logic rn, dr;
        bus.data_ready = 1'b0;
        bus.audio_in   = 16'h0;

        // 1: reset and idle at midscale
        repeat (3) step(1'b0, 16'h0, 1'b0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_pwm",   32'(pwm_out),    0);
        idle(200);
        count_high(PER, h);
        chk("idle_mid_highs", h, 8);
        chk("idle_playing", 32'(playing), 0);

        // 2: two samples, play full-scale then zero
        step(1'b1, 16'h7FFF, 1'b1);
        step(1'b1, 16'h8000, 1'b1);
        b = 0;
        while (!playing && b < 100) begin idle(1); b++; end
        chk("start_play", 32'(playing), 1);
        chk("start_no_pop", 32'(fifo_level), 2);
        b = 0;
        while (fifo_level != 1 && b < 64) begin idle(1); b++; end
        chk("pop_7fff", 32'(fifo_level), 1);
        idle(PER);
        count_high(PER, h);
        chk("period_7fff", h, 15);
        b = 0;
        while (fifo_level != 0 && b < 64) begin idle(1); b++; end
        chk("pop_8000", 32'(fifo_level), 0);
        idle(PER);
        count_high(PER, h);
        chk("period_8000", h, 0);

        // 3: underrun returns to FILL and midscale
        b = 0;
        while (!underflow && b < 64) begin idle(1); b++; end
        chk("underflow_set", 32'(underflow), 1);
        chk("underflow_fill", 32'(playing), 0);
        idle(PER);
        count_high(PER, h);
        chk("underrun_mid", h, 8);

        // 4: overfill in FILL, fifth sample dropped
        step(1'b1, 16'h1000, 1'b1);
        step(1'b1, 16'h9000, 1'b1);
        step(1'b1, 16'h4000, 1'b1);
        step(1'b1, 16'hC000, 1'b1);
        step(1'b1, 16'h7000, 1'b1);
        chk("ovf_level", 32'(fifo_level), 4);
        chk("ovf_flag",  32'(overflow),   1);
        b = 0;
        while (fifo_level != 0 && b < 400) begin idle(1); b++; end
        chk("drain", 32'(fifo_level), 0);

        // 5: push on the tick cycle at level 1
        step(1'b0, 16'h0, 1'b0);
        step(1'b1, 16'h4000, 1'b1);
        step(1'b1, 16'h2000, 1'b1);
        b = 0;
        while (fifo_level != 1 && b < 100) begin idle(1); b++; end
        chk("lvl1_play", 32'(playing), 1);
        while ((m_k % DIV) != DIV - 1) idle(1);
        step(1'b1, 16'h6000, 1'b1);
        chk("tick_push_level", 32'(fifo_level), 1);
        chk("tick_push_ovf",   32'(overflow),   0);
        chk("tick_push_unf",   32'(underflow),  0);
        while ((m_k % DIV) != DIV - 1) idle(1);
        idle(1);
        chk("pop_6000", 32'(fifo_level), 0);
        step(1'b1, 16'h1234, 1'b1);
        step(1'b1, 16'hABCD, 1'b1);
        step(1'b1, 16'h5555, 1'b1);
        idle(PER - 3);
        count_high(PER, h);
        chk("period_6000", h, 14);
        step(1'b1, 16'h0F0F, 1'b1);
        chk("pre_rst_level", 32'(fifo_level), 3);

        // 6: reset mid-PLAY
        step(1'b0, 16'h0, 1'b0);
        chk("mid_rst_level", 32'(fifo_level), 0);
        chk("mid_rst_play",  32'(playing),    0);
        chk("mid_rst_ovf",   32'(overflow),   0);
        chk("mid_rst_unf",   32'(underflow),  0);
        chk("mid_rst_pwm",   32'(pwm_out),    0);
        idle(40);
        count_high(PER, h);
        chk("post_rst_mid", h, 8);

        // random traffic with occasional resets
        repeat (3000) begin
            rn = ($urandom_range(0, 599) != 0);
            dr = ($urandom_range(0, 31) < 2);
            step(dr, 16'($urandom), rn);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
